// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - prescaled LED pattern sequencer (off / shift / flash / ping-pong)
module led_sequencer #(
   parameter int NB_LEDS    = 4,
   parameter int NB_COUNTER = 32,
   parameter int LIMIT_R0   = 2**20,
   parameter int LIMIT_R1   = 2**21,
   parameter int LIMIT_R2   = 2**22,
   parameter int LIMIT_R3   = 2**23
) (
   input  logic               clock,
   input  logic               i_reset,
   input  logic               i_enable,
   input  logic [1:0]         i_speed,
   input  logic               i_dir,
   input  logic [1:0]         i_mode,
   input  logic               i_load,
   output logic [NB_LEDS-1:0] o_led,
   output logic [1:0]         o_mode,
   output logic               o_tick
);

   typedef enum logic [1:0] {
      ST_OFF      = 2'b00,
      ST_SHIFT    = 2'b01,
      ST_FLASH    = 2'b10,
      ST_PINGPONG = 2'b11
   } state_t;

   state_t                state;
   logic [NB_COUNTER-1:0] counter;
   logic [NB_COUNTER-1:0] limit;
   logic [NB_LEDS-1:0]    led;
   logic [NB_LEDS-1:0]    next_led;
   logic [NB_LEDS-1:0]    entry_led;
   logic                  pp_dir;
   logic                  next_pp_dir;
   logic                  tick;
   logic                  step;

   always_comb begin
      limit = NB_COUNTER'(LIMIT_R0);
      case (i_speed)
         2'd0:    limit = NB_COUNTER'(LIMIT_R0);
         2'd1:    limit = NB_COUNTER'(LIMIT_R1);
         2'd2:    limit = NB_COUNTER'(LIMIT_R2);
         default: limit = NB_COUNTER'(LIMIT_R3);
      endcase
   end

   // ">=" rather than "==" so a switch to a faster speed steps at once instead of wrapping
   assign step = i_enable && (counter >= limit - NB_COUNTER'(1));

   always_comb begin
      next_led    = led;
      next_pp_dir = pp_dir;
      case (state)
         ST_OFF:   next_led = '0;
         ST_SHIFT: next_led = i_dir ? {led[0], led[NB_LEDS-1:1]}
                                    : {led[NB_LEDS-2:0], led[NB_LEDS-1]};
         ST_FLASH: next_led = ~led;
         default: begin
            // pp_dir 0 walks toward MSB; flip as the lit bit lands on an end
            if (!pp_dir) begin
               next_led = led << 1;
               if (led[NB_LEDS-2]) next_pp_dir = 1'b1;
            end else begin
               next_led = led >> 1;
               if (led[1]) next_pp_dir = 1'b0;
            end
         end
      endcase
   end

   always_comb begin
      entry_led = '0;
      case (i_mode)
         2'b00:   entry_led = '0;
         2'b10:   entry_led = '1;
         default: entry_led = NB_LEDS'(1);
      endcase
   end

   always_ff @(posedge clock) begin
      if (!i_reset) begin
         state   <= ST_OFF;
         counter <= '0;
         led     <= '0;
         pp_dir  <= 1'b0;
         tick    <= 1'b0;
      end else if (i_load) begin
         state   <= state_t'(i_mode);
         counter <= '0;
         led     <= entry_led;
         pp_dir  <= 1'b0;
         tick    <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (step) begin
            counter <= '0;
            led     <= next_led;
            pp_dir  <= next_pp_dir;
            tick    <= 1'b1;
         end else if (i_enable) begin
            counter <= counter + NB_COUNTER'(1);
         end
      end
   end

   assign o_led  = led;
   assign o_mode = state;
   assign o_tick = tick;

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - directed bench for led_sequencer (NB_LEDS=4, limits 4/8/16/32)
module tb_led_sequencer;

   logic       clock = 1'b0;
   logic       i_reset, i_enable, i_dir, i_load;
   logic [1:0] i_speed, i_mode;
   logic [3:0] o_led;
   logic [1:0] o_mode;
   logic       o_tick;

   int checks = 0;
   int errors = 0;

   led_sequencer #(
      .NB_LEDS(4), .NB_COUNTER(32),
      .LIMIT_R0(4), .LIMIT_R1(8), .LIMIT_R2(16), .LIMIT_R3(32)
   ) dut (
      .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_speed(i_speed),
      .i_dir(i_dir), .i_mode(i_mode), .i_load(i_load),
      .o_led(o_led), .o_mode(o_mode), .o_tick(o_tick)
   );

   always #5 clock = ~clock;

   task automatic cyc();
      @(negedge clock);
   endtask

   task automatic do_load(input logic [1:0] mode);
      i_mode = mode;
      i_load = 1'b1;
      cyc();
      i_load = 1'b0;
   endtask

   // n-1 quiet cycles (no tick, pattern held) followed by one step cycle
   task automatic expect_step(input string name, input int n, input logic [3:0] prev,
                              input logic [3:0] exp_led);
      for (int i = 0; i < n - 1; i++) begin
         cyc();
         checks++;
         if (o_tick !== 1'b0 || o_led !== prev) begin
            errors++;
            $display("FAIL %s quiet cycle %0d: led=%b tick=%b, required led=%b tick=0",
                     name, i, o_led, o_tick, prev);
         end
      end
      cyc();
      checks++;
      if (o_tick !== 1'b1 || o_led !== exp_led) begin
         errors++;
         $display("FAIL %s step: led=%b tick=%b, required led=%b tick=1",
                  name, o_led, o_tick, exp_led);
      end
   endtask

   task automatic test_reset();
      int ticks;
      i_reset = 1'b0; i_enable = 1'b1; i_speed = 2'd0; i_dir = 1'b0;
      i_mode = 2'b01; i_load = 1'b1;
      cyc(); cyc(); cyc();
      checks++;
      if (o_led !== 4'b0000 || o_mode !== 2'b00 || o_tick !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: led=%b mode=%b tick=%b, required 0000 00 0",
                  o_led, o_mode, o_tick);
      end
      i_load = 1'b0;
      i_reset = 1'b1;
      ticks = 0;
      for (int i = 0; i < 16; i++) begin
         cyc();
         if (o_tick === 1'b1) ticks++;
         checks++;
         if (o_led !== 4'b0000 || o_mode !== 2'b00) begin
            errors++;
            $display("FAIL off_persist: led=%b mode=%b, required 0000 00", o_led, o_mode);
         end
      end
      checks++;
      if (ticks != 4) begin
         errors++;
         $display("FAIL off_ticks: got %0d ticks, required 4", ticks);
      end
   endtask

   task automatic test_shift();
      logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      i_speed = 2'd0; i_dir = 1'b0; i_enable = 1'b1;
      do_load(2'b01);
      checks++;
      if (o_led !== 4'b0001 || o_mode !== 2'b01 || o_tick !== 1'b0) begin
         errors++;
         $display("FAIL shift_entry: led=%b mode=%b tick=%b, required 0001 01 0",
                  o_led, o_mode, o_tick);
      end
      for (int i = 1; i < 5; i++) expect_step("shift_left", 4, seq[i-1], seq[i]);
      i_dir = 1'b1;
      expect_step("shift_right", 4, 4'b0001, 4'b1000);
      expect_step("shift_right", 4, 4'b1000, 4'b0100);
   endtask

   task automatic test_flash();
      i_speed = 2'd1; i_enable = 1'b1;
      do_load(2'b10);
      checks++;
      if (o_led !== 4'b1111 || o_mode !== 2'b10) begin
         errors++;
         $display("FAIL flash_entry: led=%b mode=%b, required 1111 10", o_led, o_mode);
      end
      expect_step("flash", 8, 4'b1111, 4'b0000);
      expect_step("flash", 8, 4'b0000, 4'b1111);
      i_enable = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         checks++;
         if (o_tick !== 1'b0 || o_led !== 4'b1111 || o_mode !== 2'b10) begin
            errors++;
            $display("FAIL flash_pause cycle %0d: led=%b tick=%b mode=%b, required 1111 0 10",
                     i, o_led, o_tick, o_mode);
         end
      end
      i_enable = 1'b1;
      expect_step("flash_resume", 8, 4'b1111, 4'b0000);
   endtask

   task automatic test_pingpong();
      logic [3:0] seq [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100,
                              4'b0010, 4'b0001, 4'b0010, 4'b0100};
      i_speed = 2'd0; i_enable = 1'b1;
      do_load(2'b11);
      checks++;
      if (o_led !== 4'b0001 || o_mode !== 2'b11) begin
         errors++;
         $display("FAIL pingpong_entry: led=%b mode=%b, required 0001 11", o_led, o_mode);
      end
      for (int i = 1; i < 9; i++) begin
         for (int c = 0; c < 4; c++) begin
            i_dir = 1'($urandom_range(0, 1));
            cyc();
            checks++;
            if (c < 3 && (o_led !== seq[i-1] || o_tick !== 1'b0)) begin
               errors++;
               $display("FAIL pingpong quiet %0d: led=%b tick=%b, required %b 0",
                        i, o_led, o_tick, seq[i-1]);
            end else if (c == 3 && (o_led !== seq[i] || o_tick !== 1'b1)) begin
               errors++;
               $display("FAIL pingpong step %0d: led=%b tick=%b, required %b 1",
                        i, o_led, o_tick, seq[i]);
            end
         end
      end
   endtask

   task automatic test_speed_change();
      i_speed = 2'd3; i_dir = 1'b0; i_enable = 1'b1;
      do_load(2'b01);
      for (int i = 0; i < 20; i++) begin
         cyc();
         checks++;
         if (o_tick !== 1'b0 || o_led !== 4'b0001) begin
            errors++;
            $display("FAIL slow_count cycle %0d: led=%b tick=%b, required 0001 0",
                     i, o_led, o_tick);
         end
      end
      i_speed = 2'd0;
      expect_step("speed_drop", 1, 4'b0001, 4'b0010);
      expect_step("speed_after", 4, 4'b0010, 4'b0100);
   endtask

   task automatic test_back_to_back();
      i_speed = 2'd0; i_dir = 1'b0; i_enable = 1'b1;
      do_load(2'b01);
      expect_step("pre_collide", 4, 4'b0001, 4'b0010);
      cyc(); cyc(); cyc();
      do_load(2'b01);
      checks++;
      if (o_led !== 4'b0001 || o_tick !== 1'b0 || o_mode !== 2'b01) begin
         errors++;
         $display("FAIL load_vs_step: led=%b tick=%b mode=%b, required 0001 0 01",
                  o_led, o_tick, o_mode);
      end
      expect_step("post_collide", 4, 4'b0001, 4'b0010);
   endtask

   task automatic test_reset_mid();
      i_speed = 2'd1; i_enable = 1'b1;
      do_load(2'b10);
      cyc(); cyc(); cyc();
      i_reset = 1'b0; i_load = 1'b1; i_mode = 2'b10;
      cyc();
      checks++;
      if (o_led !== 4'b0000 || o_mode !== 2'b00 || o_tick !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: led=%b mode=%b tick=%b, required 0000 00 0",
                  o_led, o_mode, o_tick);
      end
      i_reset = 1'b1; i_load = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         checks++;
         if (o_led !== 4'b0000 || o_mode !== 2'b00) begin
            errors++;
            $display("FAIL reset_off_persist: led=%b mode=%b, required 0000 00", o_led, o_mode);
         end
      end
   endtask

   initial begin
      test_reset();
      test_shift();
      test_flash();
      test_pingpong();
      test_speed_change();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
